spm_boot_loader: RTL and testbench
==================================

Name: spm_boot_loader

Overview:
Parametrised program loader and run supervisor for the RISC_SPM processor.
- Zero-fills the SPM memory, then accepts a framed program image on a valid/ready byte stream and writes it into memory.
- Checks the image checksum, releases the CPU from reset, and monitors it until HALT or a cycle-limit timeout.
- Sits between the bench or host link and the RISC_SPM memory write port and CPU reset.

Parameters:
DATA_W, 8, memory word and stream width; DATA_W >= ADDR_W is required.
ADDR_W, 8, memory address width; memory depth is 2**ADDR_W.
CYC_W, 16, width of the run-cycle counter and cycle limit.

Ports:
clk  in  1  system clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
restart  in  1  one-cycle pulse; honoured only in DONE or FAIL.
max_cycles  in  CYC_W  run-cycle limit; sampled on entry to RUN.
in_valid  in  1  stream word valid.
in_data  in  DATA_W  stream word.
in_ready  out  1  loader accepts a word this cycle.
mem_we  out  1  memory write strobe.
mem_addr  out  ADDR_W  memory write address.
mem_wdata  out  DATA_W  memory write data.
cpu_rst  out  1  active-high hold for the CPU; the top level adapts polarity.
cpu_halted  in  1  CPU reached HALT; level.
run_cycles  out  CYC_W  cycles spent in RUN.
done  out  1  program halted cleanly; level.
err  out  1  load or run failure; level.
err_code  out  2  0 none, 1 checksum, 2 timeout.

Behaviour:
- Reset values, registered at the edge where rst=1: state CLEAR, clear counter 0, mem_we 0, mem_addr 0, mem_wdata 0, in_ready 0, cpu_rst 1, run_cycles 0, done 0, err 0, err_code 0.
- Reset mid-operation: rst overrides restart and all stream traffic. Any partially loaded image is abandoned and CLEAR restarts from address 0.
- A stream transfer occurs when in_valid and in_ready are both high. in_ready is high only in states ADDR, LEN, DATA and CSUM.
- All outputs are registered. A memory write appears one cycle after its cause.
- CLEAR: writes 0 to addresses 0..2**ADDR_W-1, one per cycle, with mem_we=1. There are exactly 2**ADDR_W write cycles, then the FSM goes to ADDR.
- ADDR: the accepted word's low ADDR_W bits become the write pointer. Go to LEN.
- LEN: the accepted word is N-1, where N is the payload word count (1..2**DATA_W). Clear the checksum accumulator, then go to DATA.
- DATA: each accepted word produces mem_we=1, mem_addr=pointer and mem_wdata=word on the next cycle.
  - The pointer increments modulo 2**ADDR_W, wrapping 2**ADDR_W-1 to 0.
  - The accumulator adds the word modulo 2**DATA_W.
  - After N words, go to CSUM.
- CSUM: accept one word.
  - If accumulator + word == 0 (mod 2**DATA_W), latch max_cycles, clear run_cycles and go to RUN.
  - Otherwise set err=1 and err_code=1, and go to FAIL; cpu_rst stays 1.
- RUN: cpu_rst=0 and run_cycles increments every cycle.
  - cpu_halted=1: set done=1, freeze run_cycles and go to DONE. cpu_rst stays 0, so the CPU remains halted and observable.
  - If run_cycles reaches the latched limit first: set cpu_rst=1, err=1, err_code=2, and go to FAIL.
  - If halt and limit occur in the same cycle, halt wins (DONE).
  - A latched limit of 0 means no limit.
- DONE/FAIL: outputs hold until restart=1. Restart clears done, err and err_code, and re-enters CLEAR.
- The FSM never asserts mem_we outside CLEAR and DATA.
- in_valid outside the ready states is ignored and has no effect.

Decomposition:
- Package spm_pkg: state enum (CLEAR, ADDR, LEN, DATA, CSUM, RUN, DONE, FAIL), err_code constants (ERR_NONE, ERR_CSUM, ERR_TIMEOUT), and the default widths.
- One sub-module, spm_run_monitor: RUN-state cycle counter, limit compare, and halt/timeout priority.

Test Plan:
1. Reset with ADDR_W=8 -> exactly 256 consecutive mem_we cycles, addr 0..255, wdata 0; then in_ready=1.
2. Stream 0x00, 0x0A, then 11 program bytes (0x00, 0x54, 0x80, 0x50, 0x81, 0x24, 0x80, 0x82, 0x73, 0x83, 0xF0), then a valid checksum -> 11 writes to addr 0..10 with matching data; cpu_rst falls in the cycle after the checksum beat.
3. Stream 0xFE, 0x02, payload 0x11 0x22 0x33, checksum 0x9A -> writes land at 0xFE, 0xFF, 0x00 (wrap); the load is accepted.
4. Same as 3 but checksum 0x00 -> err=1, err_code=1, cpu_rst remains 1, no RUN; a restart pulse returns to CLEAR.
5. Valid load with max_cycles=50; cpu_halted rises after 30 RUN cycles -> done=1, run_cycles=30. Repeat with no halt -> err_code=2 and cpu_rst=1 at run_cycles=50. Also check halt coinciding with the limit -> done.
6. Assert rst for 1 cycle midway through DATA, with in_valid held high -> in_ready=0 and mem_we=0 at the next edge, then a full 256-cycle CLEAR from address 0.

Source files
------------

// File: rtl/spm_pkg.sv
// Shared types and defaults for the RISC_SPM program loader.
package spm_pkg;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_ADDR_W = 8;
    localparam int unsigned DEF_CYC_W  = 16;

    typedef enum logic [2:0] {
        CLEAR,
        ADDR,
        LEN,
        DATA,
        CSUM,
        RUN,
        DONE,
        FAIL
    } state_e;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_CSUM    = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    // States in which the stream is accepted.
    function automatic logic is_ready(state_e s);
        return (s == ADDR) || (s == LEN) || (s == DATA) || (s == CSUM);
    endfunction

endpackage

// File: rtl/spm_boot_loader_if.sv
// Byte-stream input and memory write port between host link, loader and SPM memory.
interface spm_boot_loader_if
    import spm_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    modport master (
        output in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/spm_run_monitor.sv
// Counts CPU run cycles and resolves halt versus cycle-limit timeout (halt wins).
module spm_run_monitor
    import spm_pkg::*;
#(
    parameter int unsigned CYC_W = DEF_CYC_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             active,
    input  logic             cpu_halted,
    input  logic [CYC_W-1:0] max_cycles,
    output logic [CYC_W-1:0] run_cycles,
    output logic             halt_evt,
    output logic             timeout_evt
);
    localparam logic [CYC_W-1:0] CYC_ONE = {{(CYC_W-1){1'b0}}, 1'b1};

    logic [CYC_W-1:0] limit_q;

    // A latched limit of zero disables the timeout.
    assign halt_evt    = active && cpu_halted;
    assign timeout_evt = active && !cpu_halted && (limit_q != '0) && (run_cycles == limit_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            run_cycles <= '0;
            limit_q    <= '0;
        end else if (start) begin
            run_cycles <= '0;
            limit_q    <= max_cycles;
        end else if (active && !halt_evt && !timeout_evt) begin
            run_cycles <= run_cycles + CYC_ONE;
        end
    end

endmodule

// File: rtl/spm_boot_loader.sv
// Zero-fills SPM memory, loads a framed checksummed image, then supervises the CPU run.
module spm_boot_loader
    import spm_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned CYC_W  = DEF_CYC_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             restart,
    input  logic [CYC_W-1:0] max_cycles,
    spm_boot_loader_if.slave bus,
    output logic             cpu_rst,
    input  logic             cpu_halted,
    output logic [CYC_W-1:0] run_cycles,
    output logic             done,
    output logic             err,
    output logic [1:0]       err_code
);
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0] DATA_ONE = {{(DATA_W-1){1'b0}}, 1'b1};

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_q, ptr_q, mem_addr_q;
    logic [DATA_W-1:0] len_q, cnt_q, acc_q, mem_wdata_q;
    logic [DATA_W-1:0] csum_sum;
    logic              mem_we_q, in_ready_q;
    logic              xfer, csum_ok, run_start, run_active, halt_evt, timeout_evt;

    assign xfer       = bus.in_valid && in_ready_q;
    assign csum_sum   = acc_q + bus.in_data;
    assign csum_ok    = (csum_sum == '0);
    assign run_start  = (state_q == CSUM) && xfer && csum_ok;
    assign run_active = (state_q == RUN);

    assign bus.in_ready  = in_ready_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

    spm_run_monitor #(
        .CYC_W(CYC_W)
    ) u_run_monitor (
        .clk        (clk),
        .rst        (rst),
        .start      (run_start),
        .active     (run_active),
        .cpu_halted (cpu_halted),
        .max_cycles (max_cycles),
        .run_cycles (run_cycles),
        .halt_evt   (halt_evt),
        .timeout_evt(timeout_evt)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            CLEAR:      if (clr_q == '1) state_d = ADDR;
            ADDR:       if (xfer) state_d = LEN;
            LEN:        if (xfer) state_d = DATA;
            DATA:       if (xfer && (cnt_q == len_q)) state_d = CSUM;
            CSUM:       if (xfer) state_d = csum_ok ? RUN : FAIL;
            RUN: begin
                if (halt_evt) state_d = DONE;
                else if (timeout_evt) state_d = FAIL;
            end
            DONE, FAIL: if (restart) state_d = CLEAR;
            default:    state_d = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= CLEAR;
            clr_q       <= '0;
            ptr_q       <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            in_ready_q  <= 1'b0;
            cpu_rst     <= 1'b1;
            done        <= 1'b0;
            err         <= 1'b0;
            err_code    <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            // Registered so in_ready always matches the state it will be sampled in.
            in_ready_q <= is_ready(state_d);
            mem_we_q   <= 1'b0;
            case (state_q)
                CLEAR: begin
                    mem_we_q    <= 1'b1;
                    mem_addr_q  <= clr_q;
                    mem_wdata_q <= '0;
                    clr_q       <= clr_q + ADDR_ONE;
                end
                ADDR: if (xfer) ptr_q <= bus.in_data[ADDR_W-1:0];
                LEN: if (xfer) begin
                    len_q <= bus.in_data;
                    cnt_q <= '0;
                    acc_q <= '0;
                end
                DATA: if (xfer) begin
                    mem_we_q    <= 1'b1;
                    mem_addr_q  <= ptr_q;
                    mem_wdata_q <= bus.in_data;
                    ptr_q       <= ptr_q + ADDR_ONE;
                    acc_q       <= csum_sum;
                    cnt_q       <= cnt_q + DATA_ONE;
                end
                CSUM: if (xfer) begin
                    if (csum_ok) begin
                        cpu_rst <= 1'b0;
                    end else begin
                        err      <= 1'b1;
                        err_code <= ERR_CSUM;
                    end
                end
                RUN: begin
                    if (halt_evt) begin
                        done <= 1'b1;
                    end else if (timeout_evt) begin
                        cpu_rst  <= 1'b1;
                        err      <= 1'b1;
                        err_code <= ERR_TIMEOUT;
                    end
                end
                DONE, FAIL: if (restart) begin
                    done     <= 1'b0;
                    err      <= 1'b0;
                    err_code <= ERR_NONE;
                    cpu_rst  <= 1'b1;
                    clr_q    <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spm_boot_loader.sv
// Randomized bench for spm_boot_loader with a write scoreboard and a run-outcome model.
module tb_spm_boot_loader;

    localparam int DW    = 8;
    localparam int AW    = 8;
    localparam int CW    = 16;
    localparam int DEPTH = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic          restart;
    logic          cpu_halted;
    logic [CW-1:0] max_cycles;
    logic [CW-1:0] run_cycles;
    logic          cpu_rst;
    logic          done;
    logic          err;
    logic [1:0]    err_code;

    spm_boot_loader_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    spm_boot_loader #(
        .DATA_W(DW),
        .ADDR_W(AW),
        .CYC_W (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .restart   (restart),
        .max_cycles(max_cycles),
        .bus       (bus),
        .cpu_rst   (cpu_rst),
        .cpu_halted(cpu_halted),
        .run_cycles(run_cycles),
        .done      (done),
        .err       (err),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    int          vectors     = 0;
    int          miscompares = 0;
    bit          mon_on      = 1'b0;
    logic [15:0] exp_q[$];      // expected writes {addr, data}
    logic [7:0]  seen_addr[$];  // observed write addresses
    logic [7:0]  payload[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Write scoreboard and ready-window check, sampled away from the active edge.
    always @(negedge clk) begin
        logic [15:0] e;
        if (mon_on) begin
            if (bus.mem_we) begin
                check("write_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("mem_addr", bus.mem_addr, e[15:8]);
                    check("mem_wdata", bus.mem_wdata, e[7:0]);
                end
                seen_addr.push_back(bus.mem_addr);
            end
            if (!cpu_rst || done || err) check("ready_outside_load", bus.in_ready, 0);
        end
    end

    function automatic logic [7:0] neg_sum();
        logic [7:0] s;
        s = 8'h00;
        foreach (payload[i]) s = s + payload[i];
        return 8'h00 - s;
    endfunction

    task automatic push_clear();
        for (int i = 0; i < DEPTH; i++) exp_q.push_back({8'(i), 8'h00});
    endtask

    // Entered at a negedge with mem_we low; leaves aligned to posedge+1.
    task automatic wait_clear();
        int n;
        n = 0;
        for (int g = 0; g < DEPTH + 8; g++) begin
            @(negedge clk);
            if (bus.mem_we) n++;
            else if (n > 0) break;
        end
        check("clear_write_count", n, DEPTH);
        check("ready_after_clear", bus.in_ready, 1);
        check("clear_queue_drained", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        #1;
        exp_q.delete();
        mon_on = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        push_clear();
        @(negedge clk);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_mem_we", bus.mem_we, 0);
        check("rst_flags", {done, err, err_code, cpu_rst}, 5'b00001);
        check("rst_run_cycles", run_cycles, 0);
        bus.in_valid = 1'b0;
        wait_clear();
    endtask

    task automatic do_restart();
        bus.in_valid = 1'b0;
        cpu_halted   = 1'b0;
        @(posedge clk);
        #1 restart = 1'b1;
        push_clear();
        @(posedge clk);
        #1 restart = 1'b0;
        @(negedge clk);
        check("restart_flags", {done, err, err_code, cpu_rst}, 5'b00001);
        wait_clear();
    endtask

    // Called and returns at posedge+1; returns just after the accepting edge.
    task automatic send(input logic [7:0] w);
        bit r;
        r = 1'b0;
        bus.in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        for (int g = 0; g < 64; g++) begin
            @(negedge clk);
            r = bus.in_ready;
            @(posedge clk);
            #1;
            if (r) break;
        end
        check("send_accepted", r, 1);
        bus.in_valid = 1'b0;
    endtask

    task automatic load(input logic [7:0] a, input logic [7:0] cs, output bit ok);
        int sum;
        sum = 0;
        seen_addr.delete();
        foreach (payload[i]) begin
            exp_q.push_back({8'(int'(a) + i), payload[i]});
            sum += int'(payload[i]);
        end
        ok = ((sum + int'(cs)) % 256) == 0;
        send(a);
        send(8'(payload.size() - 1));
        foreach (payload[i]) send(payload[i]);
        check("cpu_held_before_csum", cpu_rst, 1);
        send(cs);
        if (!ok) begin
            @(negedge clk);
            check("csum_fail_flags", {done, err, err_code, cpu_rst}, 5'b01011);
            bus.in_valid = 1'b1;
            bus.in_data  = 8'($urandom);
            repeat (3) @(negedge clk);
            check("csum_fail_hold", {done, err, err_code, cpu_rst}, 5'b01011);
        end
    endtask

    // Halt is raised after observing run_cycles == h (h < 0: never).
    task automatic run_prog(input int lim, input int h);
        int         k;
        int         exp_rc;
        bit         fin;
        logic [4:0] exp_flags;
        k = 0;
        fin = 1'b0;
        exp_rc = 0;
        exp_flags = 5'b00000;
        while (!fin && k <= 300) begin
            @(negedge clk);
            check("run_cycles", run_cycles, k);
            check("run_cpu_released", cpu_rst, 0);
            check("run_flags", {done, err, err_code}, 0);
            max_cycles   = 16'($urandom);
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.in_data  = 8'($urandom);
            if (k == h) begin
                cpu_halted = 1'b1;
                exp_rc = k;
                exp_flags = 5'b10000;
                fin = 1'b1;
            end else if (lim != 0 && k == lim) begin
                exp_rc = lim;
                exp_flags = 5'b01101;
                fin = 1'b1;
            end
            if (fin) begin
                @(negedge clk);
                check("end_flags", {done, err, err_code, cpu_rst}, exp_flags);
                check("end_cycles", run_cycles, exp_rc);
            end
            k++;
        end
        check("run_terminated", fin, 1);
        repeat (3) @(negedge clk);
        check("hold_flags", {done, err, err_code, cpu_rst}, exp_flags);
        check("hold_cycles", run_cycles, exp_rc);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         ok;
        logic [7:0] a;
        logic [7:0] cs;
        int         n;
        int         lim;
        int         h;

        rst          = 1'b1;
        restart      = 1'b0;
        cpu_halted   = 1'b0;
        max_cycles   = '0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;

        do_reset();

        // Restart outside DONE/FAIL must be ignored: any CLEAR write would be unexpected.
        restart = 1'b1;
        @(posedge clk);
        #1 restart = 1'b0;

        // Reference program; hand-computed checksum 0x4F.
        payload = {8'h00, 8'h54, 8'h80, 8'h50, 8'h81, 8'h24, 8'h80, 8'h82, 8'h73, 8'h83, 8'hF0};
        max_cycles = 16'd50;
        load(8'h00, 8'h4F, ok);
        check("prog_write_count", seen_addr.size(), 11);
        check("prog_last_addr", seen_addr[10], 8'd10);
        run_prog(50, 30);
        check("prog_run_cycles", run_cycles, 30);
        check("prog_done", done, 1);
        do_restart();

        // Wrapping load, then timeout at the limit.
        payload = {8'h11, 8'h22, 8'h33};
        max_cycles = 16'd50;
        load(8'hFE, 8'h9A, ok);
        check("wrap_addr0", seen_addr[0], 8'hFE);
        check("wrap_addr1", seen_addr[1], 8'hFF);
        check("wrap_addr2", seen_addr[2], 8'h00);
        run_prog(50, -1);
        check("timeout_code", err_code, 2);
        do_restart();

        // Same image with a bad checksum.
        load(8'hFE, 8'h00, ok);
        check("csum_code", err_code, 1);
        check("csum_cpu_held", cpu_rst, 1);
        do_restart();

        // Halt in the same cycle the limit is reached.
        payload = {8'hA5};
        max_cycles = 16'd50;
        load(8'h40, 8'h5B, ok);
        run_prog(50, 50);
        check("coincide_done", done, 1);
        do_restart();

        // Limit of zero: no timeout.
        payload = {8'h01, 8'h02};
        max_cycles = 16'd0;
        load(8'h80, neg_sum(), ok);
        run_prog(0, 70);
        do_restart();

        // Maximum-length image covering the whole memory.
        payload.delete();
        for (int i = 0; i < 256; i++) payload.push_back(8'($urandom));
        max_cycles = 16'd10;
        load(8'h10, neg_sum(), ok);
        run_prog(10, 3);
        do_restart();

        // Reset in the middle of DATA with in_valid held high.
        payload.delete();
        for (int i = 0; i < 10; i++) payload.push_back(8'($urandom));
        send(8'h20);
        send(8'd9);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({8'(32 + i), payload[i]});
            send(payload[i]);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h77;
        do_reset();

        for (int it = 0; it < 8; it++) begin
            a = 8'($urandom);
            n = int'($urandom_range(1, 12));
            payload.delete();
            for (int i = 0; i < n; i++) payload.push_back(8'($urandom));
            cs = neg_sum();
            if ($urandom_range(0, 3) == 0) cs = cs + 8'($urandom_range(1, 255));
            lim = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 40));
            if (lim == 0) h = int'($urandom_range(0, 40));
            else if ($urandom_range(0, 1) == 1) h = int'($urandom_range(0, lim));
            else h = -1;
            max_cycles = 16'(lim);
            load(a, cs, ok);
            if (ok) run_prog(lim, h);
            do_restart();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
